// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package pattern_det_pkg;

  localparam int PAT_W_MAX = 32;
  localparam int LEN_MIN   = 2;
  localparam int LEN_W_MAX = $clog2(PAT_W_MAX + 1);

  typedef struct packed {
    logic [PAT_W_MAX-1:0] pattern;
    logic [LEN_W_MAX-1:0] len;
    logic                 overlap;
  } cfg_t;

  // Ones in the low len bits; history bits above the pattern length are ignored.
  function automatic logic [PAT_W_MAX-1:0] len_mask(input logic [LEN_W_MAX-1:0] len);
    logic [PAT_W_MAX-1:0] m;
    m = {PAT_W_MAX{1'b0}};
    for (int i = 0; i < PAT_W_MAX; i++) begin
      m[i] = (LEN_W_MAX'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count registered events, clear and reset win over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector with run-time pattern, length and
// overlap mode, registered match pulse and saturating match counter.
module seq_pattern_detector
  import pattern_det_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_i,
  input  logic             valid_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cfg_overlap_i,
  output logic             match_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             cfg_err_o
);

  localparam logic [LEN_W_MAX-1:0] PAT_LEN_C = LEN_W_MAX'(PAT_W);
  localparam logic [LEN_W_MAX-1:0] LEN_MIN_C = LEN_W_MAX'(LEN_MIN);

  cfg_t                 r_cfg;
  logic [PAT_W-1:0]     r_hist;
  logic [LEN_W_MAX-1:0] r_fill;
  logic                 r_match;
  logic                 r_err;

  logic [LEN_W_MAX-1:0] w_len_in;
  logic                 w_cfg_bad;
  logic                 w_enabled;
  logic                 w_consume;
  logic [PAT_W-1:0]     w_new_hist;
  logic [LEN_W_MAX-1:0] w_new_fill;
  logic [PAT_W_MAX-1:0] w_mask;
  logic [PAT_W_MAX-1:0] w_diff;
  logic                 w_hit;

  assign w_len_in   = LEN_W_MAX'(cfg_len_i);
  assign w_cfg_bad  = (w_len_in < LEN_MIN_C) || (w_len_in > PAT_LEN_C);
  // Zero length after reset keeps the block idle until the first legal load.
  assign w_enabled  = !r_err && (r_cfg.len >= LEN_MIN_C);
  assign w_consume  = valid_i && !cfg_load_i && w_enabled;
  assign w_new_hist = {r_hist[PAT_W-2:0], d_i};
  assign w_new_fill = (r_fill >= PAT_LEN_C) ? PAT_LEN_C : (r_fill + LEN_W_MAX'(1));
  assign w_mask     = len_mask(r_cfg.len);
  assign w_diff     = (PAT_W_MAX'(w_new_hist) ^ r_cfg.pattern) & w_mask;
  assign w_hit      = w_consume && (w_new_fill >= r_cfg.len) &&
                      (w_diff == {PAT_W_MAX{1'b0}});

  // Config latch, history shift register and registered match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg   <= '{pattern: {PAT_W_MAX{1'b0}}, len: {LEN_W_MAX{1'b0}}, overlap: 1'b0};
      r_hist  <= {PAT_W{1'b0}};
      r_fill  <= {LEN_W_MAX{1'b0}};
      r_match <= 1'b0;
      r_err   <= 1'b0;
    end else if (cfg_load_i) begin
      r_cfg.pattern <= PAT_W_MAX'(cfg_pattern_i);
      r_cfg.len     <= w_len_in;
      r_cfg.overlap <= cfg_overlap_i;
      r_hist        <= {PAT_W{1'b0}};
      r_fill        <= {LEN_W_MAX{1'b0}};
      r_match       <= 1'b0;
      r_err         <= w_cfg_bad;
    end else if (w_consume) begin
      r_match <= w_hit;
      if (w_hit && !r_cfg.overlap) begin
        r_hist <= {PAT_W{1'b0}};
        r_fill <= {LEN_W_MAX{1'b0}};
      end else begin
        r_hist <= w_new_hist;
        r_fill <= w_new_fill;
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_hit),
    .clr (1'b0),
    .q   (match_cnt_o)
  );

  assign match_o   = r_match;
  assign cfg_err_o = r_err;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (default and CNT_W=2 builds).
module tb_seq_pattern_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_i;
  logic        valid_i;
  logic        load_a;
  logic        load_b;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        match_a;
  logic [15:0] cnt_a;
  logic        err_a;
  logic        match_b;
  logic [1:0]  cnt_b;
  logic        err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(8), .CNT_W(16)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .d_i           (d_i),
    .valid_i       (valid_i),
    .cfg_load_i    (load_a),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .match_o       (match_a),
    .match_cnt_o   (cnt_a),
    .cfg_err_o     (err_a)
  );

  seq_pattern_detector #(.PAT_W(8), .CNT_W(2)) u_sat (
    .clk           (clk),
    .rst           (rst),
    .d_i           (d_i),
    .valid_i       (valid_i),
    .cfg_load_i    (load_b),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .match_o       (match_b),
    .match_cnt_o   (cnt_b),
    .cfg_err_o     (err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; match_o is sampled 1 time unit after the edge.
  task automatic step(input logic d, input logic v, input logic exp_m, input string tag);
    d_i = d;
    valid_i = v;
    @(posedge clk);
    #1;
    chk(tag, {31'd0, match_a}, {31'd0, exp_m});
    valid_i = 1'b0;
  endtask

  task automatic load(input logic tgt_b, input logic [7:0] pat, input logic [3:0] len,
                      input logic ov, input logic exp_err, input string tag);
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ov;
    load_a = !tgt_b;
    load_b = tgt_b;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    load_b = 1'b0;
    if (tgt_b) chk(tag, {31'd0, err_b}, {31'd0, exp_err});
    else       chk(tag, {31'd0, err_a}, {31'd0, exp_err});
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp, input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, exp[i], tag);
  endtask

  initial begin
    rst = 1'b1; d_i = 1'b0; valid_i = 1'b0; load_a = 1'b0; load_b = 1'b0;
    cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_match", {31'd0, match_a}, 32'd0);
    chk("reset_cnt", {16'd0, cnt_a}, 32'd0);
    chk("reset_err", {31'd0, err_a}, 32'd0);
    // Unconfigured block must ignore a stream.
    stream(16'b1111, 4, 16'b0000, "unconfigured");

    // Non-overlap 10110, stream 1011010110: hits on bits 5 and 10.
    load(1'b0, 8'b10110, 4'd5, 1'b0, 1'b0, "load_10110_err");
    stream(16'b1011010110, 10, 16'b0000100001, "nonov_10110");
    chk("nonov_10110_cnt", {16'd0, cnt_a}, 32'd2);

    // Overlap 1011, stream 1011011: hits on bits 4 and 7.
    load(1'b0, 8'b1011, 4'd4, 1'b1, 1'b0, "load_1011_ov");
    stream(16'b1011011, 7, 16'b0001001, "ov_1011");
    chk("ov_1011_cnt", {16'd0, cnt_a}, 32'd4);

    // Same stream, non-overlap: only bit 4 hits.
    load(1'b0, 8'b1011, 4'd4, 1'b0, 1'b0, "load_1011_nonov");
    stream(16'b1011011, 7, 16'b0001000, "nonov_1011");
    chk("nonov_1011_cnt", {16'd0, cnt_a}, 32'd5);

    // Gapped stream: three idle cycles (random data) before every bit.
    load(1'b0, 8'b10110, 4'd5, 1'b0, 1'b0, "load_gap");
    for (int i = 4; i >= 0; i--) begin
      for (int g = 0; g < 3; g++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, "gap_idle");
      step(8'b10110 >> i, 1'b1, (i == 0), "gap_bit");
    end
    step(1'b0, 1'b0, 1'b0, "gap_after");
    chk("gap_cnt", {16'd0, cnt_a}, 32'd6);

    // Reset mid-pattern discards history, count and config.
    stream(16'b1011, 4, 16'b0000, "pre_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_match", {31'd0, match_a}, 32'd0);
    chk("rst_mid_cnt", {16'd0, cnt_a}, 32'd0);
    step(1'b0, 1'b1, 1'b0, "post_reset_bit");
    chk("post_reset_cnt", {16'd0, cnt_a}, 32'd0);

    // Illegal lengths latch the error and block detection.
    load(1'b0, 8'b1, 4'd1, 1'b1, 1'b1, "len1_err");
    stream(16'b111101, 6, 16'b000000, "len1_stream");
    load(1'b0, 8'hFF, 4'd9, 1'b1, 1'b1, "len9_err");
    stream(16'b11111111, 8, 16'b00000000, "len9_stream");
    chk("err_cnt_hold", {16'd0, cnt_a}, 32'd0);
    load(1'b0, 8'b101, 4'd3, 1'b1, 1'b0, "len3_ok");
    stream(16'b10101, 5, 16'b00101, "len3_stream");
    chk("len3_cnt", {16'd0, cnt_a}, 32'd2);

    // Load and a valid bit in the same cycle: the bit is discarded.
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1;
    load_a = 1'b1; d_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1;
    load_a = 1'b0;
    step(1'b1, 1'b1, 1'b0, "load_discard_bit");
    step(1'b1, 1'b1, 1'b1, "load_discard_hit");

    // CNT_W=2 build: six 1s against overlap 11 give 5 hits, count stops at 3.
    load(1'b1, 8'b11, 4'd2, 1'b1, 1'b0, "sat_load");
    for (int i = 0; i < 6; i++) begin
      d_i = 1'b1;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      chk("sat_match", {31'd0, match_b}, {31'd0, (i >= 1)});
      chk("sat_cnt", {30'd0, cnt_b}, (i >= 3) ? 32'd3 : 32'(i));
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_idle_match", {31'd0, match_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
